booth_seq_mult: RTL and testbench

//  Iterative radix-2 Booth multiplier controller. It replaces the fully unrolled Booth step chain with one shared add/sub-and-shift step.

---
 rtl/booth_seq_mult_if.sv | 25 ++
 rtl/booth_seq_mult.sv | 94 +++++++++
 tb/tb_booth_seq_mult.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_mult_if.sv
// Handshake bundle for the sequential Booth multiplier: operand channel,
// product channel, flush and busy status.
interface booth_seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, mcand, mplier, flush, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, mcand, mplier, flush, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one shared add/sub-and-shift step per
// clock for WIDTH cycles, valid/ready on both sides, signed operands.
module booth_seq_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_seq_mult_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]           state;
    logic [WIDTH:0]       acc;
    logic [WIDTH-1:0]     mq;
    logic                 q_m1;
    logic [WIDTH-1:0]     mcand_r;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_r;

    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       acc_sum;
    logic [WIDTH:0]       acc_sh;
    logic [WIDTH-1:0]     q_sh;

    // A carries one guard bit so subtracting M = -2**(WIDTH-1) cannot overflow.
    assign m_ext = {mcand_r[WIDTH-1], mcand_r};

    always_comb begin
        acc_sum = acc;
        case ({mq[0], q_m1})
            2'b01:   acc_sum = acc + m_ext;
            2'b10:   acc_sum = acc - m_ext;
            default: acc_sum = acc;
        endcase
    end

    assign acc_sh = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    assign q_sh   = {acc_sum[0], mq[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            mq        <= '0;
            q_m1      <= 1'b0;
            mcand_r   <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mcand_r <= bus.mcand;
                        mq      <= bus.mplier;
                        acc     <= '0;
                        q_m1    <= 1'b0;
                        cnt     <= CNT_INIT;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_sh;
                    mq   <= q_sh;
                    q_m1 <= mq[0];
                    cnt  <= cnt - CNT_ONE;
                    // The final step's shifted result is captured directly as the product.
                    if (cnt == CNT_ONE) begin
                        product_r <= {acc_sh[WIDTH-1:0], q_sh};
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_RUN) || (state == ST_DONE);
    assign bus.product   = product_r;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed spec vectors, handshake
// scenarios and randomized operands against a plain signed-multiply model.
module tb_booth_seq_mult;
    localparam int WIDTH   = 32;
    localparam int CNT_W   = 6;
    localparam int LAT     = WIDTH + 1;
    localparam int TIMEOUT = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    booth_seq_mult_if #(.WIDTH(WIDTH)) bus ();

    booth_seq_mult #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Present one operand pair for a single edge; caller guarantees in_ready.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.mcand    = a;
        bus.mplier   = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mcand    = $urandom;
        bus.mplier   = $urandom;
    endtask

    // Cycles counted from the accepting edge (which is cycle 1).
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.mcand     = '0;
        bus.mplier    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [4] = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'd5, 32'h0000_0006, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [63:0] ve [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFD6,
                                 64'h4000_0000_0000_0000, 64'h0000_0000_8000_0000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            wait_done(lat);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, LAT);
            end
            checks++;
            if (bus.product !== ve[i]) begin
                errors++;
                $display("[TB] FAIL directed_product[%0d]: got %h, want %h", i, bus.product, ve[i]);
            end
            consume();
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] exp;
        int lat;
        exp = ref_mul(32'h1234_5678, 32'hFFFF_FF00);
        start_op(32'h1234_5678, 32'hFFFF_FF00);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.product !== exp) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b busy=%b product=%h, want 1 0 1 %h",
                         i, bus.out_valid, bus.in_ready, bus.busy, bus.product, exp);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_release_same_cycle: in_ready=%b, want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_to_idle: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op(32'd3, 32'd5);
        repeat (8) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(32'd2, 32'd2);
        wait_done(lat);
        checks++;
        if (lat != LAT || bus.product !== 64'h4) begin
            errors++;
            $display("[TB] FAIL after_reset_2x2: latency=%0d product=%h, want %0d 4", lat, bus.product, LAT);
        end
        consume();
    endtask

    task automatic test_ignore_busy();
        int lat;
        start_op(32'd7, 32'd11);
        bus.in_valid = 1'b1;
        bus.mcand    = 32'd9;
        bus.mplier   = 32'd9;
        wait_done(lat);
        checks++;
        if (lat != LAT || bus.product !== 64'd77) begin
            errors++;
            $display("[TB] FAIL busy_ignore_first: latency=%0d product=%h, want %0d 77", lat, bus.product, LAT);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_ignore_idle: in_ready=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != LAT || bus.product !== 64'd81) begin
            errors++;
            $display("[TB] FAIL busy_ignore_9x9: latency=%0d product=%h, want %0d 81", lat, bus.product, LAT);
        end
        consume();
    endtask

    task automatic test_flush();
        int  lat;
        bit  seen;
        start_op(32'd1000, 32'd1000);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.product !== 64'd81) begin
            errors++;
            $display("[TB] FAIL flush_run: in_ready=%b busy=%b out_valid=%b product=%h, want 1 0 0 51",
                     bus.in_ready, bus.busy, bus.out_valid, bus.product);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL flush_no_output: out_valid seen=1, want 0");
        end

        // Flush wins over a simultaneous in_valid while idle.
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.mcand    = 32'd4;
        bus.mplier   = 32'd4;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_over_in_valid: busy=%b in_ready=%b, want 0 1", bus.busy, bus.in_ready);
        end

        start_op(32'd5, 32'd6);
        wait_done(lat);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.product !== 64'd30) begin
            errors++;
            $display("[TB] FAIL flush_done: out_valid=%b in_ready=%b product=%h, want 0 1 1e",
                     bus.out_valid, bus.in_ready, bus.product);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) b = corner[$urandom_range(0, 4)];
            exp = ref_mul(a, b);
            start_op(a, b);
            wait_done(lat);
            checks++;
            if (lat != LAT || bus.product !== exp) begin
                errors++;
                $display("[TB] FAIL random[%0d] %h*%h: latency=%0d product=%h, want %0d %h",
                         i, a, b, lat, bus.product, LAT, exp);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_mid_run();
        test_ignore_busy();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
